// File: rtl/mdio_peripheral_if.sv
// MDIO responder bus: the serial management line toward the controller and
// the register-file port toward PHY-side logic.
interface mdio_peripheral_if;
  logic        MDC;
  logic        MDIO_DI;
  logic        MDIO_DI_EN;
  logic        MDIO_DO;
  logic        MDIO_DO_EN;
  logic [4:0]  REG_ADDR;
  logic [15:0] REG_WDATA;
  logic        REG_WR;
  logic        REG_RD;
  logic [15:0] REG_RDATA;
  logic        FRAME_ERR;

  // Register port handshake: REG_WR, REG_RD and FRAME_ERR are one-CLK strobes with
  // no back-pressure; REG_ADDR/REG_WDATA are valid while the strobe is high, and the
  // register file must present REG_RDATA in the CLK right after REG_RD.
  modport slave (
    input  MDC, MDIO_DI, MDIO_DI_EN, REG_RDATA,
    output MDIO_DO, MDIO_DO_EN, REG_ADDR, REG_WDATA, REG_WR, REG_RD, FRAME_ERR
  );

  modport master (
    output MDC, MDIO_DI, MDIO_DI_EN, REG_RDATA,
    input  MDIO_DO, MDIO_DO_EN, REG_ADDR, REG_WDATA, REG_WR, REG_RD, FRAME_ERR
  );
endinterface

// File: rtl/mdio_peripheral.sv
// Clause-22 MDIO responder: decodes frames sampled on MDC edges in the CLK domain,
// forwards writes to a register port and shifts read data back to the controller.
module mdio_peripheral #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic             CLK,
  input  logic             RESET,
  mdio_peripheral_if.slave bus,
  output logic [3:0]       DBG_STATE
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ST    = 4'd1,
    OP    = 4'd2,
    PHYAD = 4'd3,
    REGAD = 4'd4,
    TA_WR = 4'd5,
    WDATA = 4'd6,
    TA_RD = 4'd7,
    RDATA = 4'd8,
    SKIP  = 4'd9
  } state_e;

  state_e      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic        mdc_q;
  logic        op_hi, op_hi_n;
  logic        is_rd, is_rd_n;
  logic [8:0]  hdr, hdr_n;
  logic        rd_q;
  logic [16:0] rd_sr, rd_sr_n;
  logic [4:0]  addr_n;
  logic [15:0] wdata_n;
  logic        do_n, do_en_n, wr_n, rd_n, err_n;
  logic        rise, fall;

  assign rise      = bus.MDC & ~mdc_q;
  assign fall      = ~bus.MDC & mdc_q;
  assign DBG_STATE = state;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_hi_n = op_hi;
    is_rd_n = is_rd;
    hdr_n   = hdr;
    addr_n  = bus.REG_ADDR;
    wdata_n = bus.REG_WDATA;
    do_n    = bus.MDIO_DO;
    do_en_n = bus.MDIO_DO_EN;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    err_n   = 1'b0;
    // Read data arrives one CLK after REG_RD; the trailing 1 marks the end of the word.
    rd_sr_n = rd_q ? {bus.REG_RDATA, 1'b1} : rd_sr;

    if (rise && !bus.MDIO_DI_EN && (state inside {OP, PHYAD, REGAD, TA_WR, WDATA})) begin
      err_n   = 1'b1;
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: if (rise && bus.MDIO_DI_EN && !bus.MDIO_DI) state_n = ST;
        ST: if (rise) begin
          if (!bus.MDIO_DI_EN) state_n = IDLE;
          else if (bus.MDIO_DI) begin
            state_n = OP;
            cnt_n   = '0;
          end
        end
        OP: if (rise) begin
          if (cnt == 5'd0) begin
            op_hi_n = bus.MDIO_DI;
            cnt_n   = 5'd1;
          end else begin
            cnt_n = '0;
            if (op_hi != bus.MDIO_DI) begin
              is_rd_n = op_hi;
              state_n = PHYAD;
            end else begin
              err_n   = 1'b1;
              state_n = IDLE;
            end
          end
        end
        PHYAD: if (rise) begin
          hdr_n = {hdr[7:0], bus.MDIO_DI};
          if (cnt == 5'd4) begin
            cnt_n   = '0;
            state_n = REGAD;
          end else cnt_n = cnt + 5'd1;
        end
        REGAD: if (rise) begin
          if (cnt == 5'd4) begin
            addr_n = {hdr[3:0], bus.MDIO_DI};
            cnt_n  = '0;
            if (hdr[8:4] != PHY_ADDR) state_n = SKIP;
            else if (is_rd) begin
              rd_n    = 1'b1;
              state_n = TA_RD;
            end else state_n = TA_WR;
          end else begin
            hdr_n = {hdr[7:0], bus.MDIO_DI};
            cnt_n = cnt + 5'd1;
          end
        end
        TA_WR: if (rise) begin
          if (bus.MDIO_DI != (cnt == 5'd0)) begin
            err_n   = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt == 5'd0) cnt_n = 5'd1;
          else begin
            cnt_n   = '0;
            state_n = WDATA;
          end
        end
        WDATA: if (rise) begin
          wdata_n = {bus.REG_WDATA[14:0], bus.MDIO_DI};
          if (cnt == 5'd15) begin
            wr_n    = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end else cnt_n = cnt + 5'd1;
        end
        TA_RD: begin
          // The fall before the first TA rise belongs to REGAD; drive only after it.
          if (rise && cnt == 5'd1) begin
            cnt_n   = '0;
            state_n = RDATA;
          end else if (rise) cnt_n = 5'd1;
          else if (fall && cnt == 5'd1) begin
            do_en_n = 1'b1;
            do_n    = 1'b0;
          end
        end
        RDATA: begin
          if (fall) begin
            do_n    = rd_sr[16];
            rd_sr_n = {rd_sr[15:0], 1'b0};
          end else if (rise && rd_sr == 17'h10000) begin
            do_en_n = 1'b0;
            do_n    = 1'b0;
            state_n = IDLE;
          end
        end
        SKIP: if (rise) begin
          if (cnt == 5'd17) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else cnt_n = cnt + 5'd1;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= IDLE;
      cnt            <= '0;
      mdc_q          <= 1'b0;
      op_hi          <= 1'b0;
      is_rd          <= 1'b0;
      hdr            <= '0;
      rd_q           <= 1'b0;
      rd_sr          <= '0;
      bus.MDIO_DO    <= 1'b0;
      bus.MDIO_DO_EN <= 1'b0;
      bus.REG_ADDR   <= '0;
      bus.REG_WDATA  <= '0;
      bus.REG_WR     <= 1'b0;
      bus.REG_RD     <= 1'b0;
      bus.FRAME_ERR  <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      mdc_q          <= bus.MDC;
      op_hi          <= op_hi_n;
      is_rd          <= is_rd_n;
      hdr            <= hdr_n;
      rd_q           <= bus.REG_RD;
      rd_sr          <= rd_sr_n;
      bus.MDIO_DO    <= do_n;
      bus.MDIO_DO_EN <= do_en_n;
      bus.REG_ADDR   <= addr_n;
      bus.REG_WDATA  <= wdata_n;
      bus.REG_WR     <= wr_n;
      bus.REG_RD     <= rd_n;
      bus.FRAME_ERR  <= err_n;
    end
  end

endmodule
